// File: rtl/tno_tnc_sync_gen_pkg.sv
// tno_tnc_pkg
//   Shared widths, limits and the configuration record for the TNO/TNC timing
//   source. The measurement stage imports the same tno_cfg_t.
//   tno_clip_cfg() turns a raw configuration into the form the generator runs
//   from. It forces div and pw to at least 1 and keeps pw below the period.
package tno_tnc_pkg;

   localparam int unsigned PER_W = 32;
   localparam int unsigned DIV_W = 16;
   localparam int unsigned PW_W  = 8;

   localparam logic [PER_W-1:0] MIN_PERIOD_US = PER_W'(2);

   typedef struct packed {
      logic [PER_W-1:0] period;
      logic [DIV_W-1:0] div;
      logic [PW_W-1:0]  pw;
   } tno_cfg_t;

   typedef enum logic [1:0] {
      GEN_OFF = 2'd0,
      GEN_RUN = 2'd1,
      GEN_ERR = 2'd2
   } gen_state_t;

   // With period < MIN_PERIOD_US the pw result is meaningless. The generator
   // never uses it in that case because it sits in GEN_ERR.
   function automatic tno_cfg_t tno_clip_cfg(input tno_cfg_t raw);
      tno_cfg_t res;
      res = raw;
      if (raw.div == '0) res.div = DIV_W'(1);
      if (raw.pw == '0)  res.pw  = PW_W'(1);
      if (PER_W'(res.pw) >= raw.period) res.pw = PW_W'(raw.period - PER_W'(1));
      return res;
   endfunction

endpackage

// File: rtl/tno_tnc_sync_gen_if.sv
// tno_tnc_sync_gen_if
//   Groups the run control, the configuration and the timing outputs of the
//   generator.
//   master : controller side. It drives en, cfg_* and ext_sync.
//   slave  : generator side. It drives clk1us, tick_1us, reset_TNO, reset_TNC,
//            tno_us_cnt, tnc_frame_cnt and cfg_err.
interface tno_tnc_sync_gen_if;
   import tno_tnc_pkg::*;

   logic             en;
   logic [PER_W-1:0] cfg_tno_period_us;
   logic [DIV_W-1:0] cfg_tnc_div;
   logic [PW_W-1:0]  cfg_pulse_w_us;
   logic             ext_sync;

   logic             clk1us;
   logic             tick_1us;
   logic             reset_TNO;
   logic             reset_TNC;
   logic [PER_W-1:0] tno_us_cnt;
   logic [DIV_W-1:0] tnc_frame_cnt;
   logic             cfg_err;

   modport master (
      output en, cfg_tno_period_us, cfg_tnc_div, cfg_pulse_w_us, ext_sync,
      input  clk1us, tick_1us, reset_TNO, reset_TNC, tno_us_cnt, tnc_frame_cnt, cfg_err
   );

   modport slave (
      input  en, cfg_tno_period_us, cfg_tnc_div, cfg_pulse_w_us, ext_sync,
      output clk1us, tick_1us, reset_TNO, reset_TNC, tno_us_cnt, tnc_frame_cnt, cfg_err
   );

endinterface

// File: rtl/tno_tnc_sync_gen_us_tick_div.sv
// us_tick_div
//   Divides clk_sys down to a 1 us reference.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     run        : counter runs while high; cleared to 0 while low
//     restart    : forces div_cnt to 0 in the next cycle (phase realign)
//     div_cnt    : position 0..CLK_DIV-1 inside the current microsecond
//     clk1us     : high while div_cnt < CLK_DIV/2 (registered)
//     tick_1us   : high while div_cnt == CLK_DIV-1 (registered)
//   CLK_DIV must be even and >= 4.
module us_tick_div #(
   parameter int unsigned CLK_DIV = 100,
   parameter int unsigned CW      = $clog2(CLK_DIV)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          run,
   input  logic          restart,
   output logic [CW-1:0] div_cnt,
   output logic          clk1us,
   output logic          tick_1us
);

   localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] DIV_HALF = CW'(CLK_DIV / 2);

   logic [CW-1:0] div_cnt_q, div_cnt_d;
   logic          clk1us_q, clk1us_d;
   logic          tick_1us_q, tick_1us_d;

   // The square wave and the tick are decoded from the next count. This keeps
   // them registered and still aligned with div_cnt.
   always_comb begin
      div_cnt_d = '0;
      if (run && !restart) begin
         if (div_cnt_q == DIV_LAST) div_cnt_d = '0;
         else                       div_cnt_d = div_cnt_q + CW'(1);
      end
      clk1us_d   = run && (div_cnt_d < DIV_HALF);
      tick_1us_d = run && (div_cnt_d == DIV_LAST);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_q  <= '0;
         clk1us_q   <= 1'b0;
         tick_1us_q <= 1'b0;
      end else begin
         div_cnt_q  <= div_cnt_d;
         clk1us_q   <= clk1us_d;
         tick_1us_q <= tick_1us_d;
      end
   end

   assign div_cnt  = div_cnt_q;
   assign clk1us   = clk1us_q;
   assign tick_1us = tick_1us_q;

endmodule

// File: rtl/tno_tnc_sync_gen.sv
// tno_tnc_sync_gen
//   Local timing master for the TNO/TNC stand. It builds a 1 us reference and
//   the frame strobes. reset_TNO fires every period us. reset_TNC fires on
//   every div-th TNO frame.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     bus        : tno_tnc_sync_gen_if.slave (en, cfg_*, ext_sync in;
//                  clk1us, tick_1us, reset_TNO, reset_TNC, tno_us_cnt,
//                  tnc_frame_cnt, cfg_err out)
//   Optional build macro TNO_EXT_SYNC_EN adds the ext_sync realign path: a
//   2-FF synchroniser followed by a rising-edge detect. When the macro is not
//   defined, ext_sync is ignored.
//
//   state   | meaning
//   GEN_OFF | en low or in reset; everything held at 0
//   GEN_RUN | valid configuration active; counters and strobes running
//   GEN_ERR | active period < 2; counters at 0, strobes low, reloads every cycle
module tno_tnc_sync_gen
   import tno_tnc_pkg::*;
#(
   parameter int unsigned CLK_DIV = 100
) (
   input logic                clk,
   input logic                rst_n,
   tno_tnc_sync_gen_if.slave  bus
);

   localparam int unsigned   CW       = $clog2(CLK_DIV);
   localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

   gen_state_t       state_q, state_d;
   tno_cfg_t         cfg_q, cfg_d, cfg_in;
   logic [PER_W-1:0] us_q, us_d;
   logic [DIV_W-1:0] frame_q, frame_d;
   logic             reset_tno_q, reset_tno_d;
   logic             reset_tnc_q, reset_tnc_d;
   logic             cfg_err_q, cfg_err_d;
   logic             load, restart, sync_edge;
   logic [CW-1:0]    div_cnt;
   logic             clk1us, tick_1us;

   assign cfg_in = {bus.cfg_tno_period_us, bus.cfg_tnc_div, bus.cfg_pulse_w_us};

`ifdef TNO_EXT_SYNC_EN
   logic [2:0] sync_q, sync_d;

   always_comb begin
      sync_d = {sync_q[1:0], bus.ext_sync};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= '0;
      else        sync_q <= sync_d;
   end

   assign sync_edge = sync_q[1] & ~sync_q[2];
`else
   logic unused_ext_sync;
   assign unused_ext_sync = bus.ext_sync;
   assign sync_edge       = 1'b0;
`endif

   us_tick_div #(
      .CLK_DIV (CLK_DIV),
      .CW      (CW)
   ) u_us_tick_div (
      .clk      (clk),
      .rst_n    (rst_n),
      .run      (bus.en),
      .restart  (restart),
      .div_cnt  (div_cnt),
      .clk1us   (clk1us),
      .tick_1us (tick_1us)
   );

   always_comb begin
      state_d     = GEN_OFF;
      cfg_d       = '0;
      us_d        = '0;
      frame_d     = '0;
      load        = 1'b0;
      restart     = 1'b0;
      reset_tno_d = 1'b0;
      reset_tnc_d = 1'b0;
      cfg_err_d   = 1'b0;

      if (bus.en) begin
         state_d = state_q;
         cfg_d   = cfg_q;
         us_d    = us_q;
         frame_d = frame_q;
         // In GEN_ERR the configuration is resampled every cycle. A valid
         // period therefore takes effect as soon as it appears.
         load    = (state_q != GEN_RUN) || sync_edge;
         restart = (state_q == GEN_OFF) || sync_edge;

         // A sync edge that lands on a natural wrap takes the load path. It
         // produces one wrap, not two strobes.
         if (!load && div_cnt == DIV_LAST) begin
            if (us_q == cfg_q.period - PER_W'(1)) begin
               us_d = '0;
               if (frame_q == cfg_q.div - DIV_W'(1)) begin
                  frame_d = '0;
                  load    = 1'b1;
               end else begin
                  frame_d = frame_q + DIV_W'(1);
               end
            end else begin
               us_d = us_q + PER_W'(1);
            end
         end

         if (load) begin
            cfg_d   = tno_clip_cfg(cfg_in);
            us_d    = '0;
            frame_d = '0;
            if (cfg_in.period < MIN_PERIOD_US) begin
               state_d = GEN_ERR;
            end else begin
               state_d = GEN_RUN;
               // On recovery from an error, realign the divider so that the
               // first frame is a full period.
               if (state_q == GEN_ERR) restart = 1'b1;
            end
         end

         reset_tno_d = (state_d == GEN_RUN) && (PER_W'(cfg_d.pw) > us_d);
         reset_tnc_d = reset_tno_d && (frame_d == '0);
         cfg_err_d   = (state_d == GEN_ERR);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= GEN_OFF;
         cfg_q       <= '0;
         us_q        <= '0;
         frame_q     <= '0;
         reset_tno_q <= 1'b0;
         reset_tnc_q <= 1'b0;
         cfg_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cfg_q       <= cfg_d;
         us_q        <= us_d;
         frame_q     <= frame_d;
         reset_tno_q <= reset_tno_d;
         reset_tnc_q <= reset_tnc_d;
         cfg_err_q   <= cfg_err_d;
      end
   end

   assign bus.clk1us        = clk1us;
   assign bus.tick_1us      = tick_1us;
   assign bus.reset_TNO     = reset_tno_q;
   assign bus.reset_TNC     = reset_tnc_q;
   assign bus.tno_us_cnt    = us_q;
   assign bus.tnc_frame_cnt = frame_q;
   assign bus.cfg_err       = cfg_err_q;

endmodule

// File: tb/tb_tno_tnc_sync_gen.sv
module tb_tno_tnc_sync_gen;

   localparam int unsigned CLK_DIV = 4;

   logic clk;
   logic rst_n;

   tno_tnc_sync_gen_if bus ();

   tno_tnc_sync_gen #(.CLK_DIV(CLK_DIV)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        clk1us;
      logic        tick;
      logic        tno;
      logic        tnc;
      logic        err;
      logic [31:0] us;
      logic [15:0] frame;
   } obs_t;

   typedef struct {
      logic [31:0] period;
      logic [15:0] div;
      logic [7:0]  pw;
      int          ncyc;
      int          tno_rise;
      int          tnc_rise;
      int          tno_high;
      int          err_high;
   } vec_t;

   int   n_tests = 0;
   int   n_fail  = 0;
   obs_t exp_q[$];
   obs_t cur, prev_obs;
   int   rise_tno, rise_tnc, high_tno, high_err;

   // ---------------- reference model (advances on each active edge) -------
   int unsigned m_div, m_us, m_frame, m_per, m_dv, m_pw;
   bit          m_run, m_err, m_ld, m_rd, m_new_err, m_edge;
`ifdef TNO_EXT_SYNC_EN
   bit          m_s1, m_s2, m_s3;
`endif

   function automatic obs_t model_out();
      obs_t o;
      o        = '0;
      o.clk1us = m_run && (m_div < CLK_DIV / 2);
      o.tick   = m_run && (m_div == CLK_DIV - 1);
      o.tno    = m_run && !m_err && (m_us < m_pw);
      o.tnc    = o.tno && (m_frame == 0);
      o.err    = m_err;
      o.us     = m_us;
      o.frame  = 16'(m_frame);
      return o;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_div = 0; m_us = 0; m_frame = 0; m_per = 0; m_dv = 0; m_pw = 0;
         m_run = 0; m_err = 0;
`ifdef TNO_EXT_SYNC_EN
         m_s1 = 0; m_s2 = 0; m_s3 = 0;
`endif
         exp_q.delete();
      end else begin
         m_edge = 0;
`ifdef TNO_EXT_SYNC_EN
         m_edge = m_s2 && !m_s3;
         m_s3 = m_s2; m_s2 = m_s1; m_s1 = bus.ext_sync;
`endif
         if (!bus.en) begin
            m_div = 0; m_us = 0; m_frame = 0; m_per = 0; m_dv = 0; m_pw = 0;
            m_run = 0; m_err = 0;
         end else begin
            m_ld = !m_run || m_err || m_edge;
            m_rd = !m_run || m_edge;
            if (!m_ld && m_div == CLK_DIV - 1) begin
               if (m_us + 1 == m_per) begin
                  m_us = 0;
                  if (m_frame + 1 == m_dv) m_ld = 1;
                  else m_frame = m_frame + 1;
               end else begin
                  m_us = m_us + 1;
               end
            end
            if (m_ld) begin
               m_new_err = (bus.cfg_tno_period_us < 2);
               if (m_err && !m_new_err) m_rd = 1;
               m_err   = m_new_err;
               m_per   = bus.cfg_tno_period_us;
               m_dv    = (bus.cfg_tnc_div == 0) ? 1 : 32'(bus.cfg_tnc_div);
               m_pw    = (bus.cfg_pulse_w_us == 0) ? 1 : 32'(bus.cfg_pulse_w_us);
               if (m_pw >= m_per) m_pw = m_per - 1;
               m_us    = 0;
               m_frame = 0;
            end
            m_div = m_rd ? 0 : (m_div + 1) % CLK_DIV;
            m_run = 1;
         end
         exp_q.push_back(model_out());
      end
   end

   // ---------------- helpers ----------------------------------------------
   function automatic obs_t dut_obs();
      obs_t o;
      o.clk1us = bus.clk1us;
      o.tick   = bus.tick_1us;
      o.tno    = bus.reset_TNO;
      o.tnc    = bus.reset_TNC;
      o.err    = bus.cfg_err;
      o.us     = bus.tno_us_cnt;
      o.frame  = bus.tnc_frame_cnt;
      return o;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, req, $time);
      end
   endtask

   // One clock: sample at the falling edge, compare against the scoreboard,
   // update strobe statistics.
   task automatic tick();
      obs_t e;
      @(negedge clk);
      prev_obs = cur;
      cur      = dut_obs();
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("scoreboard", 64'(cur), 64'(e));
      end
      if (cur.tno && !prev_obs.tno) rise_tno++;
      if (cur.tnc && !prev_obs.tnc) rise_tnc++;
      if (cur.tno) high_tno++;
      if (cur.err) high_err++;
   endtask

   task automatic wait_rise_tno(input int max_cyc, output int n);
      n = -1;
      for (int i = 1; i <= max_cyc; i++) begin
         tick();
         if (cur.tno && !prev_obs.tno) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic set_cfg(input logic [31:0] p, input logic [15:0] d, input logic [7:0] w);
      bus.cfg_tno_period_us = p;
      bus.cfg_tnc_div       = d;
      bus.cfg_pulse_w_us    = w;
   endtask

   task automatic wait_us(input int unsigned target, output int found);
      found = 0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (cur.us == target) begin
            found = 1;
            break;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout at t=%0t", $time);
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ---------------------------------------------
   vec_t vecs[6];
   int   n, found;

   initial begin
      // period, div, pw, cycles, tno rises, tnc rises, tno high cycles, err cycles
      vecs[0] = '{32'd10, 16'd2, 8'd3,   200, 5, 3, 60,  0};
      vecs[1] = '{32'd1,  16'd3, 8'd1,   40,  0, 0, 0,  40};
      vecs[2] = '{32'd5,  16'd0, 8'd0,   100, 5, 5, 20,  0};
      vecs[3] = '{32'd6,  16'd1, 8'd255, 48,  2, 2, 40,  0};
      vecs[4] = '{32'd2,  16'd3, 8'd1,   48,  6, 2, 24,  0};
      vecs[5] = '{32'd0,  16'd1, 8'd4,   30,  0, 0, 0,  30};

      cur = '0; prev_obs = '0;
      rst_n = 1'b0;
      bus.en = 1'b0;
      bus.ext_sync = 1'b0;
      set_cfg(32'd10, 16'd2, 8'd3);
      repeat (3) @(negedge clk);
      check("reset_state", 64'(dut_obs()), 64'd0);
      rst_n = 1'b1;
      tick(); tick();

      // Table-driven frame statistics.
      for (int v = 0; v < 6; v++) begin
         bus.en = 1'b0;
         tick(); tick();
         set_cfg(vecs[v].period, vecs[v].div, vecs[v].pw);
         bus.en = 1'b1;
         rise_tno = 0; rise_tnc = 0; high_tno = 0; high_err = 0;
         repeat (vecs[v].ncyc) tick();
         check($sformatf("vec%0d_tno_rises", v), 64'(rise_tno), 64'(vecs[v].tno_rise));
         check($sformatf("vec%0d_tnc_rises", v), 64'(rise_tnc), 64'(vecs[v].tnc_rise));
         check($sformatf("vec%0d_tno_high",  v), 64'(high_tno), 64'(vecs[v].tno_high));
         check($sformatf("vec%0d_err_high",  v), 64'(high_err), 64'(vecs[v].err_high));
      end

      // Error recovery: period 1, then period 8 -> restart from us 0, frame 32 clk.
      bus.en = 1'b0;
      tick(); tick();
      set_cfg(32'd1, 16'd1, 8'd2);
      bus.en = 1'b1;
      repeat (10) tick();
      check("err_held", 64'(cur.err), 64'd1);
      set_cfg(32'd8, 16'd1, 8'd2);
      tick();
      check("err_cleared", 64'(cur.err), 64'd0);
      check("err_recover_tno", 64'(cur.tno), 64'd1);
      check("err_recover_us0", 64'(cur.us), 64'd0);
      wait_rise_tno(100, n);
      check("err_recover_period", 64'(n), 64'd32);

      // Shadowing: period change mid TNC frame waits for frame_cnt to return to 0.
      bus.en = 1'b0;
      tick(); tick();
      set_cfg(32'd10, 16'd2, 8'd2);
      bus.en = 1'b1;
      tick();
      wait_rise_tno(100, n);
      check("shadow_old_period", 64'(n), 64'd40);
      repeat (10) tick();
      set_cfg(32'd5, 16'd2, 8'd2);
      wait_rise_tno(100, n);
      check("shadow_old_holds", 64'(n), 64'd30);
      check("shadow_tnc_at_reload", 64'(cur.tnc), 64'd1);
      wait_rise_tno(100, n);
      check("shadow_new_period", 64'(n), 64'd20);

      // en dropped at us_cnt=3 while the strobe is high, then re-enabled.
      bus.en = 1'b0;
      tick(); tick();
      set_cfg(32'd10, 16'd2, 8'd5);
      bus.en = 1'b1;
      wait_us(3, found);
      check("en_drop_reach_us3", 64'(found), 64'd1);
      check("en_drop_mid_strobe", 64'(cur.tno), 64'd1);
      bus.en = 1'b0;
      tick();
      check("en_drop_all_zero", 64'(cur), 64'd0);
      bus.en = 1'b1;
      tick();
      check("reenable_tno", 64'(cur.tno), 64'd1);
      check("reenable_tnc", 64'(cur.tnc), 64'd1);
      check("reenable_us0", 64'(cur.us), 64'd0);

      // Asynchronous reset in mid-operation.
      repeat (6) tick();
      #2 rst_n = 1'b0;
      #1 check("async_reset_clears", 64'(dut_obs()), 64'd0);
      tick();
      rst_n = 1'b1;
      tick();
      check("post_reset_tno", 64'(cur.tno), 64'd1);
      check("post_reset_us0", 64'(cur.us), 64'd0);

      // ext_sync pulse at us_cnt=7.
      bus.en = 1'b0;
      tick(); tick();
      set_cfg(32'd20, 16'd2, 8'd3);
      bus.en = 1'b1;
      wait_us(7, found);
      check("ext_reach_us7", 64'(found), 64'd1);
      bus.ext_sync = 1'b1;
      tick();
      bus.ext_sync = 1'b0;
      tick();
      check("ext_no_early_strobe", 64'(cur.tno), 64'd0);
      tick();
`ifdef TNO_EXT_SYNC_EN
      check("ext_tno_rise", 64'(cur.tno), 64'd1);
      check("ext_tnc_rise", 64'(cur.tnc), 64'd1);
      check("ext_us_restart", 64'(cur.us), 64'd0);
`else
      check("ext_ignored_tno", 64'(cur.tno), 64'd0);
      check("ext_ignored_us", 64'(cur.us), 64'd7);
`endif
      repeat (20) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
